// File: rtl/modbus_tx_framer.sv
// modbus_tx_framer: assembles a Modbus RTU response frame (header/echo,
// DPRAM read words, CRC-16) and streams it byte-wise over valid/ready.
// Optional feature macro: MODBUS_TX_DE_EN adds an RS-485 driver-enable
// output held DE_HOLD clocks past the final byte (HOLD state + counter).
module modbus_tx_framer #(
  parameter logic [7:0]  SADDR   = 8'h01,
  parameter logic [15:0] DE_HOLD = 16'd1000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        handler_done,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic [7:0]  tx_quantity,
  input  logic [7:0]  exception_code,
  output logic [7:0]  dpram_raddr,
  input  logic [15:0] dpram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_frame_done,
  output logic        tx_de
);

  typedef enum logic [3:0] {
    IDLE, HDR, RD, RDW, DHI, DLO, CRCL, CRCH, DONE
`ifdef MODBUS_TX_DE_EN
    , HOLD
`endif
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_func, r_qty, r_exc, r_k;
  logic [15:0] r_addr, r_data, r_word, r_crc;
  logic [2:0]  r_idx;
  logic        w_hs, w_active, w_hold_act, w_discard, w_accept, w_hdr_last;

  // One full byte of reflected CRC-16 (poly A001), unrolled into one clock.
  function automatic logic [15:0] f_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign w_hs       = tx_valid && tx_ready;
  assign w_active   = r_state inside {HDR, RD, RDW, DHI, DLO, CRCL, CRCH};
  // Normal responses for anything but 03/04/06 produce no frame at all.
  assign w_discard  = (exception_code == 8'h00) &&
                      !(func_code inside {8'h03, 8'h04, 8'h06});
  assign w_accept   = handler_done && !tx_busy && (r_state inside {IDLE, DONE});
  // 06 echoes six header bytes; exceptions and reads carry three.
  assign w_hdr_last = (r_exc == 8'h00 && r_func == 8'h06) ? (r_idx == 3'd5)
                                                          : (r_idx == 3'd2);
  assign tx_valid      = r_state inside {HDR, DHI, DLO, CRCL, CRCH};
  assign tx_frame_done = (r_state == DONE);
  assign dpram_raddr   = r_k;
  assign tx_busy       = w_active || w_hold_act;

`ifdef MODBUS_TX_DE_EN
  logic [15:0] r_hold;
  assign w_hold_act = (r_state inside {DONE, HOLD}) && (r_hold != 16'd0);
  assign tx_de      = tx_busy;

  // Driver-enable hold counter, loaded on the final CRC byte handshake.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in)                                  r_hold <= 16'd0;
    else if (r_state == CRCH && w_hs)               r_hold <= DE_HOLD;
    else if (w_hold_act)                            r_hold <= r_hold - 16'd1;
`else
  logic w_unused_de_hold;
  assign w_unused_de_hold = ^DE_HOLD;
  assign w_hold_act       = 1'b0;
  assign tx_de            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_next;

  // Next-state logic; byte states advance only on their handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept && !w_discard) w_next = HDR;
      HDR:  if (w_hs && w_hdr_last)
              w_next = (r_exc != 8'h00 || r_func == 8'h06 || r_qty == 8'h00) ? CRCL : RD;
      RD:   w_next = RDW;
      RDW:  w_next = DHI;
      DHI:  if (w_hs) w_next = DLO;
      DLO:  if (w_hs) w_next = (({1'b0, r_k} + 9'd1) < {1'b0, r_qty}) ? RD : CRCL;
      CRCL: if (w_hs) w_next = CRCH;
      CRCH: if (w_hs) w_next = DONE;
      DONE: begin
        w_next = IDLE;
        if (w_accept && !w_discard) w_next = HDR;
`ifdef MODBUS_TX_DE_EN
        if (r_hold > 16'd1) w_next = HOLD;
`endif
      end
`ifdef MODBUS_TX_DE_EN
      HOLD: if (r_hold <= 16'd1) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Outgoing byte mux; held stable by the registers it reads while stalled.
  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      HDR: case (r_idx)
        3'd0:    tx_data = SADDR;
        3'd1:    tx_data = (r_exc != 8'h00) ? (r_func | 8'h80) : r_func;
        3'd2:    tx_data = (r_exc != 8'h00) ? r_exc :
                           (r_func == 8'h06) ? r_addr[15:8] : {r_qty[6:0], 1'b0};
        3'd3:    tx_data = r_addr[7:0];
        3'd4:    tx_data = r_data[15:8];
        3'd5:    tx_data = r_data[7:0];
        default: tx_data = 8'h00;
      endcase
      DHI:     tx_data = r_word[15:8];
      DLO:     tx_data = r_word[7:0];
      CRCL:    tx_data = r_crc[7:0];
      CRCH:    tx_data = r_crc[15:8];
      default: tx_data = 8'h00;
    endcase
  end

  // Request latch, CRC accumulation, header index and DPRAM word index.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_func <= 8'h00; r_addr <= 16'h0000; r_data <= 16'h0000;
      r_qty  <= 8'h00; r_exc  <= 8'h00;    r_crc  <= 16'hFFFF;
      r_idx  <= 3'd0;  r_k    <= 8'h00;    r_word <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_func <= func_code; r_addr <= addr; r_data <= data;
        r_qty  <= tx_quantity; r_exc <= exception_code;
        r_crc  <= 16'hFFFF; r_idx <= 3'd0; r_k <= 8'h00;
      end
      if (w_hs && (r_state inside {HDR, DHI, DLO})) r_crc <= f_crc(r_crc, tx_data);
      if (w_hs && r_state == HDR) r_idx <= r_idx + 3'd1;
      if (w_hs && r_state == DLO) r_k   <= r_k + 8'd1;
      if (r_state == RDW)         r_word <= dpram_rdata;
    end

endmodule

// File: tb/tb_modbus_tx_framer.sv
// Randomised bench for modbus_tx_framer: expected frames come from a
// byte-list model of the response rules; one monitor checks every cycle.
`timescale 1ns/1ps
module tb_modbus_tx_framer;
  localparam logic [7:0] SADDR = 8'h01;
  localparam int DEH = 10;
  typedef logic [7:0] bq_t [$];

  logic clk_in = 1'b0, rst_n_in = 1'b0, handler_done = 1'b0;
  logic [7:0]  func_code = 8'h00, tx_quantity = 8'h00, exception_code = 8'h00;
  logic [15:0] addr = 16'h0000, data = 16'h0000, dpram_rdata;
  logic [7:0]  dpram_raddr, tx_data;
  logic        tx_valid, tx_busy, tx_frame_done, tx_de;
  logic        tx_ready = 1'b1;
  logic        rnd_ready = 1'b0;
  logic [15:0] mem [256];

  int   total = 0, bad = 0, cyc = 0, t_n = 0, fd_off = 0;
  bq_t  exp_q;
  int   hs_off [$];
  logic [7:0] bub_q [$];
  logic frame_open = 1'b0, fd_seen = 1'b0, st_valid = 1'b0;
  logic [7:0] st_data = 8'h00;
`ifdef MODBUS_TX_DE_EN
  logic de_wait = 1'b0;
  int   last_hs = 0;
`endif

  modbus_tx_framer #(.SADDR(SADDR), .DE_HOLD(16'(DEH))) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .handler_done(handler_done),
    .func_code(func_code), .addr(addr), .data(data), .tx_quantity(tx_quantity),
    .exception_code(exception_code), .dpram_raddr(dpram_raddr),
    .dpram_rdata(dpram_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_frame_done(tx_frame_done),
    .tx_de(tx_de));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;
  always @(posedge clk_in) dpram_rdata <= mem[dpram_raddr];
  always @(posedge clk_in) begin
    #1 tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Whole response as a byte list, CRC appended low byte first.
  function automatic bq_t model(input logic [7:0] f, input logic [15:0] a, d,
                                input logic [7:0] q, e);
    bq_t b;
    logic [15:0] c;
    logic [7:0] q2;
    b.push_back(SADDR);
    if (e != 0) begin
      b.push_back(f | 8'h80); b.push_back(e);
    end else if (f == 8'h06) begin
      b.push_back(f); b.push_back(a[15:8]); b.push_back(a[7:0]);
      b.push_back(d[15:8]); b.push_back(d[7:0]);
    end else begin
      q2 = 8'(int'(q) * 2);
      b.push_back(f); b.push_back(q2);
      for (int k = 0; k < int'(q); k++) begin
        b.push_back(mem[k][15:8]); b.push_back(mem[k][7:0]);
      end
    end
    c = 16'hFFFF;
    foreach (b[i]) c = crc_step(c, b[i]);
    b.push_back(c[7:0]); b.push_back(c[15:8]);
    return b;
  endfunction

  // Cycle offset of byte j with tx_ready held high: reads add two idle
  // cycles in front of every data word.
  function automatic int exp_off(input logic [7:0] f, q, e, input int j);
    if (e != 0 || f == 8'h06 || j < 3) return j;
    if (j < 3 + 2 * int'(q)) return j + 2 * ((j - 3) / 2 + 1);
    return j + 2 * int'(q);
  endfunction

  // Single compare process for all outputs.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      st_valid = 1'b0;
    end else begin
      if (st_valid) begin
        chk("stall_valid_held", 32'(tx_valid), 32'd1);
        chk("stall_data_held", 32'(tx_data), 32'(st_data));
      end
      st_valid = tx_valid && !tx_ready;
      st_data  = tx_data;
      if (tx_valid) chk("busy_with_valid", 32'(tx_busy), 32'd1);
`ifdef MODBUS_TX_DE_EN
      if (tx_valid) chk("de_with_valid", 32'(tx_de), 32'd1);
      if (de_wait && !tx_de) begin
        chk("de_fall_delay", 32'(cyc - last_hs), 32'(DEH + 1));
        de_wait = 1'b0;
      end
`else
      chk("de_tied_low", 32'(tx_de), 32'd0);
`endif
      if (tx_busy && !tx_valid && exp_q.size() > 0) bub_q.push_back(dpram_raddr);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("spurious_byte", 32'(exp_q.size()), 32'd1);
        else begin
          chk("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          hs_off.push_back(cyc - t_n);
`ifdef MODBUS_TX_DE_EN
          if (exp_q.size() == 0) begin last_hs = cyc; de_wait = 1'b1; end
`endif
        end
      end
      if (tx_frame_done) begin
        chk("done_expected", 32'(frame_open), 32'd1);
        chk("done_after_all_bytes", 32'(exp_q.size()), 32'd0);
`ifndef MODBUS_TX_DE_EN
        chk("busy_falls_with_done", 32'(tx_busy), 32'd0);
`endif
        fd_seen = 1'b1; fd_off = cyc - t_n; frame_open = 1'b0;
      end
    end
  end

  task automatic start(input logic [7:0] f, input logic [15:0] a, d,
                       input logic [7:0] q, e);
    @(posedge clk_in); #1;
    func_code = f; addr = a; data = d; tx_quantity = q; exception_code = e;
    handler_done = 1'b1;
    if (e != 0 || f == 8'h03 || f == 8'h04 || f == 8'h06) begin
      exp_q = model(f, a, d, q, e); frame_open = 1'b1;
    end
    @(posedge clk_in); #1;
    t_n = cyc; handler_done = 1'b0;
    hs_off.delete(); bub_q.delete(); fd_seen = 1'b0;
  endtask

  task automatic wait_frame(input logic [7:0] f, q, e, input int nbytes);
    int n;
    n = 0;
    while (!fd_seen && n < 600) begin @(posedge clk_in); #1; n++; end
    chk("frame_completes", 32'(fd_seen), 32'd1);
    if (!fd_seen) begin exp_q.delete(); frame_open = 1'b0; end
    chk("byte_count", 32'(hs_off.size()), 32'(nbytes));
    if (!rnd_ready) begin
      foreach (hs_off[j]) chk("byte_cycle", 32'(hs_off[j]), 32'(exp_off(f, q, e, j)));
      chk("done_cycle", 32'(fd_off), 32'(exp_off(f, q, e, nbytes - 1) + 1));
    end
    if (e == 0 && f != 8'h06) begin
      chk("bubble_count", 32'(bub_q.size()), 32'(2 * int'(q)));
      foreach (bub_q[i]) chk("bubble_raddr", 32'(bub_q[i]), 32'(i / 2));
    end else chk("no_bubbles", 32'(bub_q.size()), 32'd0);
    n = 0;
    while (tx_busy && n < 200) begin @(posedge clk_in); #1; n++; end
    chk("busy_drops", 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_bytes(input int cnt);
    int n;
    n = 0;
    while (hs_off.size() < cnt && n < 200) begin @(posedge clk_in); #1; n++; end
    chk("reached_byte", 32'(hs_off.size() >= cnt), 32'd1);
  endtask

  initial begin
    bq_t b;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Pin the model against known Modbus frames.
    b = model(8'h03, 16'h0, 16'h0, 8'd0, 8'h02);
    chk("pin_exc_len", 32'(b.size()), 32'd5);
    chk("pin_exc_crc", {16'h0, b[3], b[4]}, 32'hC0F1);
    b = model(8'h06, 16'h0001, 16'h0003, 8'd0, 8'h00);
    chk("pin_06_crc", {16'h0, b[6], b[7]}, 32'h980B);
    b = model(8'h03, 16'h0, 16'h0, 8'd1, 8'h00);
    chk("pin_03_crc", {16'h0, b[5], b[6]}, 32'hB844);

    #12;
    chk("rst_outputs", {tx_data, dpram_raddr, 4'(0), tx_valid, tx_busy, tx_frame_done, tx_de}, 32'h0);
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b1;

    rnd_ready = 1'b0;
    start(8'h03, 16'h0, 16'h0, 8'd0, 8'h02); wait_frame(8'h03, 8'd0, 8'h02, 5);
    start(8'h06, 16'h0001, 16'h0003, 8'd0, 8'h00); wait_frame(8'h06, 8'd0, 8'h00, 8);
    start(8'h03, 16'h0, 16'h0, 8'd1, 8'h00); wait_frame(8'h03, 8'd1, 8'h00, 7);

    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    rnd_ready = 1'b1;
    start(8'h04, 16'h0, 16'h0, 8'd4, 8'h00); wait_frame(8'h04, 8'd4, 8'h00, 13);

    // Second handler_done mid-frame must be ignored.
    start(8'h04, 16'h0, 16'h0, 8'd4, 8'h00);
    wait_bytes(4);
    @(posedge clk_in); #1;
    func_code = 8'h06; addr = 16'hBEEF; exception_code = 8'h00; handler_done = 1'b1;
    @(posedge clk_in); #1; handler_done = 1'b0;
    wait_frame(8'h04, 8'd4, 8'h00, 13);

    // Unsupported function, normal response: dropped silently.
    rnd_ready = 1'b0;
    start(8'h05, 16'h0, 16'h0, 8'd0, 8'h00);
    repeat (10) begin @(negedge clk_in); chk("discard_idle", {tx_busy, tx_valid}, 32'd0); end

    // Asynchronous reset in the middle of a read frame.
    start(8'h04, 16'h0, 16'h0, 8'd4, 8'h00);
    wait_bytes(3);
    #2 rst_n_in = 1'b0;
    #1;
    chk("abort_valid", 32'(tx_valid), 32'd0);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_done_de", {tx_frame_done, tx_de}, 32'd0);
    exp_q.delete(); frame_open = 1'b0;
`ifdef MODBUS_TX_DE_EN
    de_wait = 1'b0;
`endif
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    start(8'h04, 16'h0, 16'h0, 8'd4, 8'h00); wait_frame(8'h04, 8'd4, 8'h00, 13);

    for (int it = 0; it < 24; it++) begin
      logic [7:0] f, q, e;
      int pick, nb;
      pick = $urandom_range(0, 5);
      f = (pick == 0) ? 8'h03 : (pick == 1) ? 8'h04 : (pick == 2) ? 8'h06 :
          (pick == 3) ? 8'h05 : 8'($urandom_range(1, 127));
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      q = 8'($urandom_range(0, 8));
      for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
      rnd_ready = 1'($urandom_range(0, 1));
      start(f, 16'($urandom), 16'($urandom), q, e);
      if (e != 0 || f == 8'h03 || f == 8'h04 || f == 8'h06) begin
        nb = (e != 0) ? 5 : (f == 8'h06) ? 8 : 5 + 2 * int'(q);
        wait_frame(f, q, e, nb);
      end else begin
        repeat (5) begin @(negedge clk_in); chk("rand_discard_idle", 32'(tx_busy), 32'd0); end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
